fb_bank_scheduler: RTL and testbench

//  Sequences all SDRAM frame-buffer traffic for the BT656 capture path. Arbitrates line-sized

---
 rtl/fb_sched_pkg.sv | 26 ++
 rtl/fb_line_addr_gen.sv | 36 +++
 rtl/fb_bank_scheduler.sv | 177 +++++++++++++++++
 tb/tb_fb_bank_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_sched_pkg.sv
// Shared types and defaults for the frame-buffer bank scheduler.
// Optional statistics are enabled with the FB_SCHED_STATS_EN macro in fb_bank_scheduler.
package fb_sched_pkg;

    typedef enum logic [2:0] {
        ARB,
        WR_REQ,
        WR_BUSY,
        RD_REQ,
        RD_BUSY
    } sched_state_t;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

    localparam logic [22:0] DEF_BUFFER_A_BASE = 23'h00000;
    localparam logic [22:0] DEF_BUFFER_B_BASE = 23'h4B000;

    // Counter must be able to hold FRAME_LINES itself, which marks a finished frame.
    function automatic int line_cnt_width(input int lines);
        return $clog2(lines + 1);
    endfunction

endpackage

// File: rtl/fb_line_addr_gen.sv
// Per-direction line counter with A/B base selection and line start address.
// wrapped is high once the counter has reached FRAME_LINES.
module fb_line_addr_gen
    import fb_sched_pkg::*;
#(
    parameter logic [22:0] BASE_A      = DEF_BUFFER_A_BASE,
    parameter logic [22:0] BASE_B      = DEF_BUFFER_B_BASE,
    parameter int          LINE_WORDS  = 640,
    parameter int          FRAME_LINES = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        buf_sel,
    input  logic        clear,
    input  logic        incr,
    output logic [22:0] addr,
    output logic        wrapped
);

    localparam int LW = line_cnt_width(FRAME_LINES);

    logic [LW-1:0] line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            line <= '0;
        else if (clear)
            line <= '0;
        else if (incr)
            line <= line + 1'b1;
    end

    assign addr    = (buf_sel ? BASE_B : BASE_A) + 23'(line) * 23'(LINE_WORDS);
    assign wrapped = (line >= LW'(FRAME_LINES));

endmodule

// File: rtl/fb_bank_scheduler.sv
// Arbitrates line transactions between camera write FIFO and display read FIFO over A/B buffers.
// Define FB_SCHED_STATS_EN to add the stat_frames / stat_starve counters.
module fb_bank_scheduler
    import fb_sched_pkg::*;
#(
    parameter logic [22:0] BUFFER_A_BASE = DEF_BUFFER_A_BASE,
    parameter logic [22:0] BUFFER_B_BASE = DEF_BUFFER_B_BASE,
    parameter int          LINE_WORDS    = 640,
    parameter int          FRAME_LINES   = 480,
    parameter logic [11:0] RD_LOW_WM     = 12'd1024,
    parameter logic [11:0] RD_CRIT_WM    = 12'd256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] wr_usedw,
    input  logic        cam_frame_start,
    input  logic [11:0] rd_usedw,
    input  logic        disp_vsync,
    output logic        req_valid,
    output logic        req_write,
    output logic [22:0] req_addr,
    output logic [1:0]  BA,
    input  logic        req_ready,
    input  logic        req_done,
    output logic        wr_buf_sel,
    output logic        rd_buf_sel,
    output logic        frame_rdy
`ifdef FB_SCHED_STATS_EN
    ,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_starve
`endif
);

    sched_state_t state, next_state;
    grant_t       last_grant;
    logic         vsync_pend, cam_pend;
    logic [22:0]  wr_addr, rd_addr;
    logic         wr_wrapped, rd_wrapped;
    logic         wr_need, rd_need, rd_crit;
    logic         grant_wr, grant_rd, wr_fin, rd_fin;
    logic         in_wr, in_rd;
    logic         vsync_now, rd_vsync_fin, swap, rd_clear, rd_incr;
    logic         cam_now, wr_restart, wr_clear, wr_incr;

    // The write counter sitting at FRAME_LINES is exactly the "frame waiting for swap" condition.
    assign frame_rdy = wr_wrapped;
    assign BA        = 2'b00;

    assign in_wr   = (state == WR_REQ) || (state == WR_BUSY);
    assign in_rd   = (state == RD_REQ) || (state == RD_BUSY);
    assign wr_need = (wr_usedw >= 12'(LINE_WORDS)) && !frame_rdy;
    assign rd_need = (rd_usedw < RD_LOW_WM) && !rd_wrapped;
    assign rd_crit = (rd_usedw < RD_CRIT_WM);

    assign vsync_now    = disp_vsync && !in_rd;
    assign rd_vsync_fin = rd_fin && (vsync_pend || disp_vsync);
    assign swap         = (vsync_now || rd_vsync_fin) && frame_rdy;
    assign rd_clear     = vsync_now || rd_vsync_fin;
    assign rd_incr      = rd_fin && !rd_vsync_fin;

    assign cam_now    = cam_frame_start && !frame_rdy && !in_wr;
    assign wr_restart = wr_fin && (cam_pend || cam_frame_start);
    assign wr_clear   = swap || cam_now || wr_restart;
    assign wr_incr    = wr_fin && !wr_restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ARB;
        else
            state <= next_state;
    end

    // A vsync or frame start in ARB moves counters/buffers, so the grant waits one cycle for them.
    always_comb begin
        next_state = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        wr_fin     = 1'b0;
        rd_fin     = 1'b0;
        case (state)
            ARB: begin
                if (!disp_vsync && !cam_frame_start) begin
                    if (wr_need && (!rd_need || (!rd_crit && last_grant == GRANT_RD))) begin
                        grant_wr   = 1'b1;
                        next_state = WR_REQ;
                    end else if (rd_need) begin
                        grant_rd   = 1'b1;
                        next_state = RD_REQ;
                    end
                end
            end
            WR_REQ:  if (req_ready) next_state = WR_BUSY;
            RD_REQ:  if (req_ready) next_state = RD_BUSY;
            WR_BUSY: if (req_done) begin wr_fin = 1'b1; next_state = ARB; end
            RD_BUSY: if (req_done) begin rd_fin = 1'b1; next_state = ARB; end
            default: next_state = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
        end else if (grant_wr) begin
            req_valid <= 1'b1;
            req_write <= 1'b1;
            req_addr  <= wr_addr;
        end else if (grant_rd) begin
            req_valid <= 1'b1;
            req_write <= 1'b0;
            req_addr  <= rd_addr;
        end else if ((state == WR_REQ || state == RD_REQ) && req_ready) begin
            req_valid <= 1'b0;
        end
    end

    // Events that land mid-transaction are parked until that transaction's req_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_buf_sel <= 1'b0;
            rd_buf_sel <= 1'b1;
            last_grant <= GRANT_RD;
            vsync_pend <= 1'b0;
            cam_pend   <= 1'b0;
        end else begin
            if (swap) begin
                wr_buf_sel <= ~wr_buf_sel;
                rd_buf_sel <= wr_buf_sel;
            end
            if (wr_fin)
                last_grant <= GRANT_WR;
            else if (rd_fin)
                last_grant <= GRANT_RD;
            if (rd_fin)
                vsync_pend <= 1'b0;
            else if (disp_vsync && in_rd)
                vsync_pend <= 1'b1;
            if (wr_fin)
                cam_pend <= 1'b0;
            else if (cam_frame_start && in_wr)
                cam_pend <= 1'b1;
        end
    end

    fb_line_addr_gen #(
        .BASE_A(BUFFER_A_BASE), .BASE_B(BUFFER_B_BASE),
        .LINE_WORDS(LINE_WORDS), .FRAME_LINES(FRAME_LINES)
    ) u_wr_gen (
        .clk(clk), .reset(reset), .buf_sel(wr_buf_sel),
        .clear(wr_clear), .incr(wr_incr), .addr(wr_addr), .wrapped(wr_wrapped)
    );

    fb_line_addr_gen #(
        .BASE_A(BUFFER_A_BASE), .BASE_B(BUFFER_B_BASE),
        .LINE_WORDS(LINE_WORDS), .FRAME_LINES(FRAME_LINES)
    ) u_rd_gen (
        .clk(clk), .reset(reset), .buf_sel(rd_buf_sel),
        .clear(rd_clear), .incr(rd_incr), .addr(rd_addr), .wrapped(rd_wrapped)
    );

`ifdef FB_SCHED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_frames <= '0;
            stat_starve <= '0;
        end else begin
            if (swap)
                stat_frames <= stat_frames + 1'b1;
            if (rd_usedw == 12'd0 && !rd_wrapped && stat_starve != 16'hFFFF)
                stat_starve <= stat_starve + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_bank_scheduler.sv
// Directed, table-driven bench for fb_bank_scheduler with hand sequences for multi-cycle cases.
// Default build only (FB_SCHED_STATS_EN undefined unless passed in).
module tb_fb_bank_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] wr_usedw = '0;
    logic        cam_frame_start = 1'b0;
    logic [11:0] rd_usedw = 12'd2000;
    logic        disp_vsync = 1'b0;
    logic        req_valid;
    logic        req_write;
    logic [22:0] req_addr;
    logic [1:0]  BA;
    logic        req_ready = 1'b0;
    logic        req_done = 1'b0;
    logic        wr_buf_sel;
    logic        rd_buf_sel;
    logic        frame_rdy;
`ifdef FB_SCHED_STATS_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_starve;
`endif

    int tests_run = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    fb_bank_scheduler dut (
        .clk(clk), .reset(reset),
        .wr_usedw(wr_usedw), .cam_frame_start(cam_frame_start),
        .rd_usedw(rd_usedw), .disp_vsync(disp_vsync),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .BA(BA),
        .req_ready(req_ready), .req_done(req_done),
        .wr_buf_sel(wr_buf_sel), .rd_buf_sel(rd_buf_sel), .frame_rdy(frame_rdy)
`ifdef FB_SCHED_STATS_EN
        , .stat_frames(stat_frames), .stat_starve(stat_starve)
`endif
    );

    typedef struct {
        logic [11:0] wr;
        logic [11:0] rd;
        logic        exp_valid;
        logic        exp_write;
        logic [22:0] exp_addr;
    } vec_t;

    vec_t vecs[8];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [11:0] wr, input logic [11:0] rd);
        wr_usedw = wr;
        rd_usedw = rd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply_stimulus(12'd0, 12'd2000);
        req_ready = 1'b0;
        req_done = 1'b0;
        disp_vsync = 1'b0;
        cam_frame_start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name, output bit ok);
        int waited = 0;
        while (!req_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        ok = req_valid;
        if (!ok) begin
            tests_run++;
            fail_count++;
            $display("[TB] FAIL %s: no req_valid within 100 cycles", name);
        end
    endtask

    task automatic serve(input logic exp_write, input logic [22:0] exp_addr, input string name);
        bit ok;
        wait_valid(name, ok);
        if (!ok) return;
        check_output({name, "_write"}, 32'(req_write), 32'(exp_write));
        check_output({name, "_addr"}, 32'(req_addr), 32'(exp_addr));
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check_output({name, "_valid_drop"}, 32'(req_valid), 32'd0);
        @(negedge clk);
        req_done = 1'b1;
        @(negedge clk);
        req_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ok;

        vecs[0] = '{12'd640, 12'd2000, 1'b1, 1'b1, 23'h00000};
        vecs[1] = '{12'd700, 12'd100,  1'b1, 1'b0, 23'h4B000};
        vecs[2] = '{12'd700, 12'd500,  1'b1, 1'b1, 23'h00000};
        vecs[3] = '{12'd639, 12'd500,  1'b1, 1'b0, 23'h4B000};
        vecs[4] = '{12'd640, 12'd255,  1'b1, 1'b0, 23'h4B000};
        vecs[5] = '{12'd640, 12'd256,  1'b1, 1'b1, 23'h00000};
        vecs[6] = '{12'd0,   12'd1024, 1'b0, 1'b0, 23'h00000};
        vecs[7] = '{12'd639, 12'd1023, 1'b1, 1'b0, 23'h4B000};

        // Reset values
        do_reset();
        check_output("rst_valid", 32'(req_valid), 32'd0);
        check_output("rst_write", 32'(req_write), 32'd0);
        check_output("rst_addr", 32'(req_addr), 32'd0);
        check_output("rst_ba", 32'(BA), 32'd0);
        check_output("rst_wr_sel", 32'(wr_buf_sel), 32'd0);
        check_output("rst_rd_sel", 32'(rd_buf_sel), 32'd1);
        check_output("rst_frame_rdy", 32'(frame_rdy), 32'd0);

        // First grant after reset for each FIFO-level pattern
        for (int i = 0; i < 8; i++) begin
            do_reset();
            apply_stimulus(vecs[i].wr, vecs[i].rd);
            for (int c = 0; c < 10 && !req_valid; c++) @(negedge clk);
            check_output($sformatf("vec%0d_valid", i), 32'(req_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check_output($sformatf("vec%0d_write", i), 32'(req_write), 32'(vecs[i].exp_write));
                check_output($sformatf("vec%0d_addr", i), 32'(req_addr), 32'(vecs[i].exp_addr));
            end
        end

        // Two consecutive writes
        do_reset();
        apply_stimulus(12'd640, 12'd2000);
        serve(1'b1, 23'd0, "t1_wr0");
        serve(1'b1, 23'd640, "t1_wr1");

        // Critical read, then alternation
        do_reset();
        apply_stimulus(12'd700, 12'd100);
        serve(1'b0, 23'h4B000, "t2_rd0");
        check_output("t2_rd_sel", 32'(rd_buf_sel), 32'd1);
        apply_stimulus(12'd700, 12'd500);
        serve(1'b1, 23'h00000, "t2_wr0");
        serve(1'b0, 23'h4B280, "t2_rd1");
        serve(1'b1, 23'h00280, "t2_wr1");

        // Full frame, stall, then swap on vsync
        do_reset();
        apply_stimulus(12'd640, 12'd2000);
        for (int i = 0; i < 480; i++) serve(1'b1, 23'(i * 640), "t3_frame");
        repeat (20) @(negedge clk);
        check_output("t3_frame_rdy", 32'(frame_rdy), 32'd1);
        check_output("t3_no_grant", 32'(req_valid), 32'd0);
        disp_vsync = 1'b1;
        @(negedge clk);
        disp_vsync = 1'b0;
        check_output("t3_wr_sel", 32'(wr_buf_sel), 32'd1);
        check_output("t3_rd_sel", 32'(rd_buf_sel), 32'd0);
        check_output("t3_frame_clr", 32'(frame_rdy), 32'd0);
        serve(1'b1, 23'h4B000, "t3_wr_b");

        // vsync during RD_BUSY is deferred to req_done
        do_reset();
        apply_stimulus(12'd640, 12'd2000);
        for (int i = 0; i < 480; i++) serve(1'b1, 23'(i * 640), "t4_frame");
        apply_stimulus(12'd0, 12'd500);
        serve(1'b0, 23'h4B000, "t4_rd0");
        serve(1'b0, 23'h4B280, "t4_rd1");
        wait_valid("t4_rd2", ok);
        check_output("t4_rd2_addr", 32'(req_addr), 32'h4B500);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        disp_vsync = 1'b1;
        @(negedge clk);
        disp_vsync = 1'b0;
        check_output("t4_defer_rd_sel", 32'(rd_buf_sel), 32'd1);
        check_output("t4_defer_wr_sel", 32'(wr_buf_sel), 32'd0);
        check_output("t4_defer_frame", 32'(frame_rdy), 32'd1);
        req_done = 1'b1;
        @(negedge clk);
        req_done = 1'b0;
        check_output("t4_rd_sel", 32'(rd_buf_sel), 32'd0);
        check_output("t4_wr_sel", 32'(wr_buf_sel), 32'd1);
        check_output("t4_frame_clr", 32'(frame_rdy), 32'd0);
        serve(1'b0, 23'h00000, "t4_rd_a0");

        // Camera restart in ARB, then latched restart with a long req_ready stall
        do_reset();
        apply_stimulus(12'd640, 12'd2000);
        for (int i = 0; i < 100; i++) serve(1'b1, 23'(i * 640), "t5_lines");
        cam_frame_start = 1'b1;
        @(negedge clk);
        cam_frame_start = 1'b0;
        serve(1'b1, 23'd0, "t5_restart0");
        serve(1'b1, 23'd640, "t5_restart1");
        wait_valid("t5_stall", ok);
        cam_frame_start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cam_frame_start = 1'b0;
            check_output($sformatf("t5_stall%0d_addr", c), 32'(req_addr), 32'd1280);
            check_output($sformatf("t5_stall%0d_valid", c), 32'(req_valid), 32'd1);
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        @(negedge clk);
        req_done = 1'b1;
        @(negedge clk);
        req_done = 1'b0;
        serve(1'b1, 23'd0, "t5_latched");

        // Reset inside WR_BUSY, then a stray req_done
        do_reset();
        apply_stimulus(12'd640, 12'd2000);
        serve(1'b1, 23'd0, "t6_wr0");
        wait_valid("t6_wr1", ok);
        check_output("t6_wr1_addr", 32'(req_addr), 32'd640);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        reset = 1'b1;
        apply_stimulus(12'd0, 12'd2000);
        #1;
        check_output("t6_rst_valid", 32'(req_valid), 32'd0);
        check_output("t6_rst_write", 32'(req_write), 32'd0);
        check_output("t6_rst_addr", 32'(req_addr), 32'd0);
        check_output("t6_rst_rd_sel", 32'(rd_buf_sel), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req_done = 1'b1;
        @(negedge clk);
        req_done = 1'b0;
        @(negedge clk);
        check_output("t6_stray_valid", 32'(req_valid), 32'd0);
        apply_stimulus(12'd640, 12'd2000);
        serve(1'b1, 23'd0, "t6_after");

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
